// File: rtl/rv32i_enc_pkg.sv
// rtl/rv32i_enc_pkg.sv - instruction classes, opcodes and immediate packing helpers
package rv32i_enc_pkg;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OPIMM  = 4'd7,
        CLS_OP     = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_SYSTEM = 4'd10,
        CLS_LI     = 4'd11
    } cls_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] FENCE_WORD = 32'h0FF0000F;

    // Each helper takes only the immediate bits that land in the word.
    function automatic logic [31:0] imm_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] imm_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // imm holds offset bits [12:1]; bit 0 is implied zero.
    function automatic logic [31:0] imm_b(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], opc};
    endfunction

    function automatic logic [31:0] imm_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    // imm holds offset bits [20:1]; bit 0 is implied zero.
    function automatic logic [31:0] imm_j(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm[19], imm[9:0], imm[10], imm[18:11], rd, opc};
    endfunction

endpackage

// File: rtl/rv32i_defs.vh
// rtl/rv32i_defs.vh - shared ALU operation and memory width codes
`ifndef RV32I_DEFS_VH
`define RV32I_DEFS_VH

`define ALU_ADD    4'd0
`define ALU_SUB    4'd1
`define ALU_SLL    4'd2
`define ALU_SLT    4'd3
`define ALU_SLTU   4'd4
`define ALU_XOR    4'd5
`define ALU_SRL    4'd6
`define ALU_SRA    4'd7
`define ALU_OR     4'd8
`define ALU_AND    4'd9
`define ALU_PASS_B 4'd10

`define MEM_BYTE   2'b00
`define MEM_HALF   2'b01
`define MEM_WORD   2'b10

`endif

// File: rtl/rv32i_encode_core.sv
// rtl/rv32i_encode_core.sv - combinational field-to-instruction encoder
`include "rv32i_defs.vh"

module rv32i_encode_core
    import rv32i_enc_pkg::*;
#(
    parameter int CHECK_IMM = 1
) (
    input  logic [3:0]  cls_i,
    input  logic [3:0]  alu_op_i,
    input  logic [1:0]  mem_width_i,
    input  logic        mem_unsigned_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i_val,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic        needs_second_o,
    output logic [31:0] second_instr_o
);

    localparam logic CHK = (CHECK_IMM != 0);

    logic [2:0]  alu_f3;
    logic        alu_alt;
    logic        alu_ok;
    logic        alu_shift;
    logic        fits_i, fits_b, fits_j, u_ok, sh_ok;
    logic [19:0] li_hi;
    logic [31:0] word;
    logic        bad;
    logic        two;

    assign fits_i = (&imm_i_val[31:11]) | ~(|imm_i_val[31:11]);
    assign fits_b = ((&imm_i_val[31:12]) | ~(|imm_i_val[31:12])) & ~imm_i_val[0];
    assign fits_j = ((&imm_i_val[31:20]) | ~(|imm_i_val[31:20])) & ~imm_i_val[0];
    assign u_ok   = ~(|imm_i_val[11:0]);
    assign sh_ok  = ~(|imm_i_val[31:5]);
    // Rounded upper part so that LUI hi + sign-extended lo reproduces imm.
    assign li_hi  = imm_i_val[31:12] + {19'd0, imm_i_val[11]};

    // Map the ALU operation to funct3 and the funct7 alternate bit.
    always_comb begin
        alu_f3    = 3'b000;
        alu_alt   = 1'b0;
        alu_ok    = 1'b1;
        alu_shift = 1'b0;
        case (alu_op_i)
            `ALU_ADD:  alu_f3 = 3'b000;
            `ALU_SUB:  begin alu_f3 = 3'b000; alu_alt = 1'b1; end
            `ALU_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
            `ALU_SLT:  alu_f3 = 3'b010;
            `ALU_SLTU: alu_f3 = 3'b011;
            `ALU_XOR:  alu_f3 = 3'b100;
            `ALU_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
            `ALU_SRA:  begin alu_f3 = 3'b101; alu_shift = 1'b1; alu_alt = 1'b1; end
            `ALU_OR:   alu_f3 = 3'b110;
            `ALU_AND:  alu_f3 = 3'b111;
            default:   alu_ok = 1'b0;
        endcase
    end

    // Build the primary word per class and flag anything unencodable.
    always_comb begin
        word           = 32'd0;
        bad            = 1'b0;
        two            = 1'b0;
        second_instr_o = 32'd0;
        case (cls_i)
            CLS_LUI: begin
                word = imm_u(imm_i_val[31:12], rd_i, OPC_LUI);
                bad  = CHK && !u_ok;
            end
            CLS_AUIPC: begin
                word = imm_u(imm_i_val[31:12], rd_i, OPC_AUIPC);
                bad  = CHK && !u_ok;
            end
            CLS_JAL: begin
                word = imm_j(imm_i_val[20:1], rd_i, OPC_JAL);
                bad  = CHK && !fits_j;
            end
            CLS_JALR: begin
                word = imm_i(imm_i_val[11:0], rs1_i, 3'b000, rd_i, OPC_JALR);
                bad  = CHK && !fits_i;
            end
            CLS_BRANCH: begin
                word = imm_b(imm_i_val[12:1], rs2_i, rs1_i, funct3_i, OPC_BRANCH);
                bad  = (funct3_i[2:1] == 2'b01) || (CHK && !fits_b);
            end
            CLS_LOAD: begin
                word = imm_i(imm_i_val[11:0], rs1_i, {mem_unsigned_i, mem_width_i}, rd_i, OPC_LOAD);
                bad  = (mem_width_i == 2'b11) || (mem_unsigned_i && mem_width_i == `MEM_WORD)
                       || (CHK && !fits_i);
            end
            CLS_STORE: begin
                word = imm_s(imm_i_val[11:0], rs2_i, rs1_i, {1'b0, mem_width_i}, OPC_STORE);
                bad  = (mem_width_i == 2'b11) || (CHK && !fits_i);
            end
            CLS_OPIMM: begin
                if (alu_shift) begin
                    word = {1'b0, alu_alt, 5'd0, imm_i_val[4:0], rs1_i, alu_f3, rd_i, OPC_OPIMM};
                    bad  = CHK && !sh_ok;
                end else begin
                    word = imm_i(imm_i_val[11:0], rs1_i, alu_f3, rd_i, OPC_OPIMM);
                    bad  = CHK && !fits_i;
                end
                if (!alu_ok || alu_op_i == `ALU_SUB) bad = 1'b1;
            end
            CLS_OP: begin
                word = {1'b0, alu_alt, 5'd0, rs2_i, rs1_i, alu_f3, rd_i, OPC_OP};
                bad  = !alu_ok;
            end
            CLS_FENCE:  word = FENCE_WORD;
            CLS_SYSTEM: word = {imm_i_val[11:0], 13'd0, OPC_SYSTEM};
            CLS_LI: begin
                if (fits_i) begin
                    word = imm_i(imm_i_val[11:0], 5'd0, 3'b000, rd_i, OPC_OPIMM);
                end else begin
                    word           = imm_u(li_hi, rd_i, OPC_LUI);
                    two            = |imm_i_val[11:0];
                    second_instr_o = imm_i(imm_i_val[11:0], rd_i, 3'b000, rd_i, OPC_OPIMM);
                end
            end
            default: bad = 1'b1;
        endcase
    end

    assign err_o          = bad;
    assign instr_o        = bad ? 32'd0 : word;
    assign needs_second_o = two && !bad;

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - request-to-instruction stream encoder with LI expansion
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int CHECK_IMM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [3:0]  req_alu_op,
    input  logic [1:0]  req_mem_width,
    input  logic        req_mem_unsigned,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT1 = 2'd1;
    localparam logic [1:0] ST_BEAT2 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [31:0] second_q, second_d;

    logic [31:0] core_instr, core_second;
    logic        core_err, core_two;
    logic        accept, fire;

    rv32i_encode_core #(.CHECK_IMM(CHECK_IMM)) u_core (
        .cls_i          (req_class),
        .alu_op_i       (req_alu_op),
        .mem_width_i    (req_mem_width),
        .mem_unsigned_i (req_mem_unsigned),
        .funct3_i       (req_funct3),
        .rd_i           (req_rd),
        .rs1_i          (req_rs1),
        .rs2_i          (req_rs2),
        .imm_i_val      (req_imm),
        .instr_o        (core_instr),
        .err_o          (core_err),
        .needs_second_o (core_two),
        .second_instr_o (core_second)
    );

    // A new request can enter whenever the output slot empties this cycle.
    assign req_ready = (state_q == ST_IDLE) || (last_q && out_ready);
    assign accept    = req_valid && req_ready;
    assign fire      = valid_q && out_ready;

    // Next-state: load a fresh request, advance to the LI second beat, or drain.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        last_d   = last_q;
        err_d    = err_q;
        second_d = second_q;
        if (accept) begin
            state_d  = ST_BEAT1;
            valid_d  = 1'b1;
            instr_d  = core_instr;
            err_d    = core_err;
            last_d   = !core_two;
            second_d = core_second;
        end else if (fire) begin
            if (!last_q) begin
                state_d = ST_BEAT2;
                instr_d = second_q;
                last_d  = 1'b1;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                instr_d = 32'd0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
        end
    end

    // Output and FSM registers; reset drops any pending second beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            instr_q  <= 32'd0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            second_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            last_q   <= last_d;
            err_q    <= err_d;
            second_q <= second_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_last  = last_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - scoreboard testbench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;
    import rv32i_enc_pkg::*;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SRA = 4'd7, A_PASSB = 4'd10;
    localparam logic [1:0] M_BYTE = 2'b00, M_WORD = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_class, req_alu_op;
    logic [1:0]  req_mem_width;
    logic        req_mem_unsigned;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid, out_ready, out_last, out_err;
    logic [31:0] out_instr;

    int tests = 0;
    int fails = 0;
    int fires = 0;
    int cyc   = 0;
    logic [33:0] sb[$];

    rv32i_instr_encoder #(.CHECK_IMM(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_alu_op(req_alu_op), .req_mem_width(req_mem_width),
        .req_mem_unsigned(req_mem_unsigned), .req_funct3(req_funct3), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every transferred beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            fires <= fires + 1;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_beat: observed instr=%h last=%b err=%b, required none", out_instr, out_last, out_err);
            end
            if (sb.size() != 0) begin
                logic [33:0] e;
                e = sb.pop_front();
                assert ({out_err, out_last, out_instr} === e) else begin
                    fails++;
                    $error("FAIL beat: observed err=%b last=%b instr=%h, required err=%b last=%b instr=%h",
                           out_err, out_last, out_instr, e[33], e[32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic last, input logic err);
        sb.push_back({err, last, instr});
    endtask

    task automatic drive(input logic [3:0] cls, input logic [3:0] alu, input logic [1:0] mw,
                         input logic mu, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int n;
        logic acc;
        req_class = cls; req_alu_op = alu; req_mem_width = mw; req_mem_unsigned = mu;
        req_funct3 = f3; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = req_ready;
            step();
            n++;
        end
        req_valid = 1'b0;
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL accept_timeout: observed no accept, required accept within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout: observed %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        int c0, f0;
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_class = '0; req_alu_op = '0; req_mem_width = '0; req_mem_unsigned = 1'b0;
        req_funct3 = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        step();

        // OP ADD with one-cycle latency.
        push(32'h002081B3, 1'b1, 1'b0);
        drive(CLS_OP, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
        step();
        drain();

        // LI expansion variants.
        push(32'h123452B7, 1'b0, 1'b0); push(32'h67828293, 1'b1, 1'b0);
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd5, 5'd0, 5'd0, 32'h12345678);
        push(32'h00001337, 1'b0, 1'b0); push(32'hFFF30313, 1'b1, 1'b0);
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd6, 5'd0, 5'd0, 32'h00000FFF);
        push(32'h000103B7, 1'b1, 1'b0);
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd7, 5'd0, 5'd0, 32'h00010000);
        push(32'hFFF00293, 1'b1, 1'b0);
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);

        // Branches, including range and alignment boundaries.
        push(32'h00208463, 1'b1, 1'b0);
        drive(CLS_BRANCH, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_BRANCH, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7);
        push(32'h80208063, 1'b1, 1'b0);
        drive(CLS_BRANCH, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFF000);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_BRANCH, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4096);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_BRANCH, A_ADD, M_BYTE, 1'b0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);

        // ALU forms.
        push(32'h402081B3, 1'b1, 1'b0);
        drive(CLS_OP, A_SUB, M_BYTE, 1'b0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
        push(32'h00208033, 1'b1, 1'b0);
        drive(CLS_OP, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd0);
        push(32'h4030D093, 1'b1, 1'b0);
        drive(CLS_OPIMM, A_SRA, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd1, 5'd0, 32'd3);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_OPIMM, A_SLL, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd1, 5'd0, 32'd32);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_OP, A_PASSB, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd1, 5'd2, 32'd0);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_OPIMM, A_SUB, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd1, 5'd0, 32'd1);

        // Memory, jumps, upper immediates, misc.
        push(32'hFFC12203, 1'b1, 1'b0);
        drive(CLS_LOAD, A_ADD, M_WORD, 1'b0, 3'b000, 5'd4, 5'd2, 5'd0, 32'hFFFFFFFC);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_LOAD, A_ADD, M_WORD, 1'b1, 3'b000, 5'd4, 5'd2, 5'd0, 32'd0);
        push(32'h00512423, 1'b1, 1'b0);
        drive(CLS_STORE, A_ADD, M_WORD, 1'b0, 3'b000, 5'd0, 5'd2, 5'd5, 32'd8);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_STORE, A_ADD, 2'b11, 1'b0, 3'b000, 5'd0, 5'd2, 5'd5, 32'd8);
        push(32'h001000EF, 1'b1, 1'b0);
        drive(CLS_JAL, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_JAL, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2049);
        push(32'h123450B7, 1'b1, 1'b0);
        drive(CLS_LUI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'h12345000);
        push(32'h0, 1'b1, 1'b1);
        drive(CLS_LUI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'h00001001);
        push(32'h0FF0000F, 1'b1, 1'b0);
        drive(CLS_FENCE, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
        push(32'h0, 1'b1, 1'b1);
        drive(4'd15, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
        drain();

        // Backpressure during LI beat 1.
        out_ready = 1'b0;
        push(32'h123452B7, 1'b0, 1'b0); push(32'h67828293, 1'b1, 1'b0);
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd5, 5'd0, 5'd0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_instr", out_instr, 32'h123452B7);
            chk("stall_last", {31'd0, out_last}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Ten back-to-back ADDs: one accept and one word per clock.
        f0 = fires;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 1);
            push({17'h00208, rd, 7'b0110011}, 1'b1, 1'b0);
            drive(CLS_OP, A_ADD, M_BYTE, 1'b0, 3'b000, rd, 5'd1, 5'd2, 32'd0);
        end
        chk("b2b_accept_cycles", 32'(cyc - c0), 32'd10);
        @(negedge clk);
        step();
        chk("b2b_words", 32'(fires - f0), 32'd10);
        drain();

        // Reset while LI beat 1 is held: beat 2 must never appear.
        out_ready = 1'b0;
        drive(CLS_LI, A_ADD, M_BYTE, 1'b0, 3'b000, 5'd5, 5'd0, 5'd0, 32'h12345678);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        f0 = fires;
        out_ready = 1'b1;
        repeat (5) step();
        chk("post_rst_no_beat", 32'(fires - f0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
